vscale_src_mux_pipe: RTL and testbench

- Parametrised, registered ALU operand-source selector for the vscale DX→EX boundary.
- Chooses one of N_SRC packed operand sources. Slot 0 is always the RS data slot.
- Slot 0 gets writeback-to-operand forwarding, gated by the register address.
- Captures the chosen operand into a pipeline register with stall-hold and kill, and keeps a saturating count of forwarded captures.

---
 rtl/vscale_src_mux_pipe.sv | 153 +++++++++++++++
 tb/tb_vscale_src_mux_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_src_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : vscale_src_mux_pipe
//  Purpose  : Registered ALU operand-source selector for the DX->EX boundary.
//             Selects one of N_SRC packed operand sources. Slot 0 (RS data)
//             can be replaced by writeback data when the writeback stage is
//             writing the same non-zero register. The result is captured into
//             an EX pipeline register that supports stall (hold) and kill
//             (bubble), and forwarded captures are counted in a saturating
//             counter.
//
//  Ports    :
//    clk           in   1                  rising-edge clock
//    reset         in   1                  asynchronous reset, active low
//    src_sel       in   SEL_W              operand source select
//    src_data      in   N_SRC*XPR_LEN      packed sources, slot i at [i*XPR_LEN +: XPR_LEN]
//    rs_addr       in   REG_ADDR_W         register address of the slot-0 operand
//    wb_wen        in   1                  writeback register-file write enable
//    wb_waddr      in   REG_ADDR_W         writeback destination address
//    wb_data       in   XPR_LEN            writeback data
//    in_valid      in   1                  DX-stage instruction valid
//    stall         in   1                  hold the EX operand register
//    kill          in   1                  squash the EX operand register
//    cnt_clr       in   1                  synchronous clear of bypass_cnt
//    alu_src       out  XPR_LEN            registered ALU operand
//    out_valid     out  1                  alu_src is valid
//    out_bypassed  out  1                  alu_src came from the forwarding path
//    bypass_cnt    out  CNT_W              saturating count of forwarded captures
//
//  Revision : 1.0  initial release
// ============================================================================
module vscale_src_mux_pipe #(
    parameter int XPR_LEN    = 32,
    parameter int N_SRC      = 4,
    parameter int SEL_W      = 2,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SEL_W-1:0]           src_sel,
    input  logic [N_SRC*XPR_LEN-1:0]   src_data,
    input  logic [REG_ADDR_W-1:0]      rs_addr,
    input  logic                       wb_wen,
    input  logic [REG_ADDR_W-1:0]      wb_waddr,
    input  logic [XPR_LEN-1:0]         wb_data,
    input  logic                       in_valid,
    input  logic                       stall,
    input  logic                       kill,
    input  logic                       cnt_clr,
    output logic [XPR_LEN-1:0]         alu_src,
    output logic                       out_valid,
    output logic                       out_bypassed,
    output logic [CNT_W-1:0]           bypass_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // Source unpacking
    // ------------------------------------------------------------------------
    logic [XPR_LEN-1:0] w_slot [N_SRC];

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
            assign w_slot[gi] = src_data[gi*XPR_LEN +: XPR_LEN];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Combinational select. Codes at or above N_SRC match no slot and leave
    // the default of zero in place.
    // ------------------------------------------------------------------------
    logic [XPR_LEN-1:0] w_sel_val;

    always_comb begin
        w_sel_val = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                w_sel_val = w_slot[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Writeback forwarding into slot 0 only. Register 0 is hard-wired zero in
    // the register file, so a write to it must never be forwarded.
    // ------------------------------------------------------------------------
    logic               w_fwd;
    logic [XPR_LEN-1:0] w_next_val;

    assign w_fwd      = (src_sel == '0) && wb_wen &&
                        (wb_waddr == rs_addr) && (rs_addr != '0);
    assign w_next_val = w_fwd ? wb_data : w_sel_val;

    // A load cycle is one where neither kill nor stall applies.
    logic w_load;
    logic w_inc;

    assign w_load = !kill && !stall;
    assign w_inc  = w_load && in_valid && w_fwd;

    // ------------------------------------------------------------------------
    // EX operand register: kill > stall > load
    // ------------------------------------------------------------------------
    logic [XPR_LEN-1:0] r_alu_src;
    logic               r_valid;
    logic               r_bypassed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_src  <= '0;
            r_valid    <= 1'b0;
            r_bypassed <= 1'b0;
        end else if (kill) begin
            r_alu_src  <= '0;
            r_valid    <= 1'b0;
            r_bypassed <= 1'b0;
        end else if (!stall) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_alu_src  <= w_next_val;
                r_bypassed <= w_fwd;
            end else begin
                r_alu_src  <= '0;
                r_bypassed <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Saturating bypass counter; clear has priority over increment and is
    // honoured regardless of stall/kill.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_inc && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign alu_src      = r_alu_src;
    assign out_valid    = r_valid;
    assign out_bypassed = r_bypassed;
    assign bypass_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vscale_src_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vscale_src_mux_pipe
//  Purpose  : Self-checking bench for vscale_src_mux_pipe, configured with
//             N_SRC=3 (one unused select code) and CNT_W=2 (fast saturation).
//             Directed scenarios followed by randomized traffic, all compared
//             against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vscale_src_mux_pipe;

    localparam int XPR_LEN    = 32;
    localparam int N_SRC      = 3;
    localparam int SEL_W      = 2;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 2;
    localparam int CNT_MAX    = 3;

    logic                      clk;
    logic                      reset;
    logic [SEL_W-1:0]          src_sel;
    logic [XPR_LEN-1:0]        slot [N_SRC];
    logic [N_SRC*XPR_LEN-1:0]  src_data;
    logic [REG_ADDR_W-1:0]     rs_addr;
    logic                      wb_wen;
    logic [REG_ADDR_W-1:0]     wb_waddr;
    logic [XPR_LEN-1:0]        wb_data;
    logic                      in_valid;
    logic                      stall;
    logic                      kill;
    logic                      cnt_clr;
    logic [XPR_LEN-1:0]        alu_src;
    logic                      out_valid;
    logic                      out_bypassed;
    logic [CNT_W-1:0]          bypass_cnt;

    assign src_data = {slot[2], slot[1], slot[0]};

    vscale_src_mux_pipe #(
        .XPR_LEN    (XPR_LEN),
        .N_SRC      (N_SRC),
        .SEL_W      (SEL_W),
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .src_sel      (src_sel),
        .src_data     (src_data),
        .rs_addr      (rs_addr),
        .wb_wen       (wb_wen),
        .wb_waddr     (wb_waddr),
        .wb_data      (wb_data),
        .in_valid     (in_valid),
        .stall        (stall),
        .kill         (kill),
        .cnt_clr      (cnt_clr),
        .alu_src      (alu_src),
        .out_valid    (out_valid),
        .out_bypassed (out_bypassed),
        .bypass_cnt   (bypass_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [XPR_LEN-1:0] exp_alu;
    logic               exp_valid;
    logic               exp_byp;
    int                 exp_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".alu_src"}, 64'(alu_src), 64'(exp_alu));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
        chk({tag, ".out_bypassed"}, 64'(out_bypassed), 64'(exp_byp));
        chk({tag, ".bypass_cnt"}, 64'(bypass_cnt), 64'(exp_cnt));
    endtask

    task automatic model_reset();
        exp_alu   = '0;
        exp_valid = 1'b0;
        exp_byp   = 1'b0;
        exp_cnt   = 0;
    endtask

    // One rising edge worth of behaviour, from the current input values.
    task automatic model_edge();
        logic [XPR_LEN-1:0] sel_val;
        logic               fwd;
        int                 s;
        s = int'(src_sel);
        sel_val = (s < N_SRC) ? slot[s] : '0;
        fwd = (s == 0) && wb_wen && (wb_waddr == rs_addr) && (rs_addr != 0);
        if (kill) begin
            exp_valid = 1'b0;
            exp_byp   = 1'b0;
            exp_alu   = '0;
        end else if (!stall) begin
            exp_valid = in_valid;
            exp_alu   = !in_valid ? '0 : (fwd ? wb_data : sel_val);
            exp_byp   = in_valid && fwd;
        end
        if (cnt_clr)
            exp_cnt = 0;
        else if (!kill && !stall && in_valid && fwd && exp_cnt < CNT_MAX)
            exp_cnt = exp_cnt + 1;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        src_sel  = '0;
        rs_addr  = '0;
        wb_wen   = 1'b0;
        wb_waddr = '0;
        wb_data  = '0;
        in_valid = 1'b0;
        stall    = 1'b0;
        kill     = 1'b0;
        cnt_clr  = 1'b0;
        for (int i = 0; i < N_SRC; i++) slot[i] = '0;
    endtask

    task automatic rand_inputs(input bit ctrl);
        src_sel  = SEL_W'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
        for (int i = 0; i < N_SRC; i++) slot[i] = $urandom;
        rs_addr  = REG_ADDR_W'($urandom_range(0, 3));
        wb_waddr = REG_ADDR_W'($urandom_range(0, 3));
        wb_wen   = ($urandom_range(0, 3) != 0);
        wb_data  = $urandom;
        in_valid = ($urandom_range(0, 4) != 0);
        stall    = ctrl && ($urandom_range(0, 6) == 0);
        kill     = ctrl && ($urandom_range(0, 9) == 0);
        cnt_clr  = ctrl && ($urandom_range(0, 19) == 0);
    endtask

    task automatic set_fwd_case(input logic [REG_ADDR_W-1:0] addr);
        src_sel  = 2'd0;
        slot[0]  = 32'h1111_1111;
        rs_addr  = addr;
        wb_wen   = 1'b1;
        wb_waddr = addr;
        wb_data  = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        stall    = 1'b0;
        kill     = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();

        // ---------------- Reset held with random inputs ----------------
        reset = 1'b0;
        #2;
        check_all("reset_async");
        for (int i = 0; i < 4; i++) begin
            rand_inputs(1'b1);
            @(posedge clk);
            #1;
            check_all("reset_hold");
        end

        // ---------------- Release, first load from slot 1 ----------------
        idle_inputs();
        reset    = 1'b1;
        src_sel  = 2'd1;
        slot[1]  = 32'h0000_0200;
        in_valid = 1'b1;
        step("first_load");
        chk("first_load.const", 64'(alu_src), 64'h200);

        // ---------------- Forwarding ----------------
        set_fwd_case(5'd5);
        step("fwd");
        chk("fwd.const_alu", 64'(alu_src), 64'hDEAD_BEEF);
        chk("fwd.const_cnt", 64'(bypass_cnt), 64'd1);

        // Address 0 never forwards
        set_fwd_case(5'd0);
        step("fwd_x0");
        chk("fwd_x0.const_alu", 64'(alu_src), 64'h1111_1111);

        // Non-zero select never forwards even on address match
        set_fwd_case(5'd7);
        src_sel = 2'd1;
        slot[1] = 32'h2222_2222;
        step("fwd_sel1");
        chk("fwd_sel1.const_byp", 64'(out_bypassed), 64'd0);

        // ---------------- Stall holds, kill beats stall ----------------
        idle_inputs();
        src_sel  = 2'd2;
        slot[2]  = 32'hCAFE_F00D;
        in_valid = 1'b1;
        step("stall_load");
        for (int i = 0; i < 3; i++) begin
            rand_inputs(1'b0);
            stall = 1'b1;
            step("stall_hold");
            chk("stall_hold.const", 64'(alu_src), 64'hCAFE_F00D);
        end
        stall = 1'b1;
        kill  = 1'b1;
        step("stall_kill");
        chk("stall_kill.const", 64'(out_valid), 64'd0);

        // ---------------- Counter saturation and clear ----------------
        set_fwd_case(5'd3);
        cnt_clr = 1'b1;
        step("cnt_clr0");
        cnt_clr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wb_data = $urandom;
            step("cnt_sat");
            chk("cnt_sat.const", 64'(bypass_cnt), 64'((i > 3) ? 3 : i));
        end
        cnt_clr = 1'b1;
        step("cnt_clr_wins");
        chk("cnt_clr_wins.const", 64'(bypass_cnt), 64'd0);
        cnt_clr = 1'b0;
        step("cnt_one");
        stall = 1'b1;
        step("cnt_stalled");
        chk("cnt_stalled.const", 64'(bypass_cnt), 64'd1);
        stall   = 1'b0;
        kill    = 1'b1;
        step("cnt_killed");
        kill    = 1'b0;

        // ---------------- Out-of-range select ----------------
        set_fwd_case(5'd4);
        src_sel = 2'd3;
        step("sel_oor");
        chk("sel_oor.const_alu", 64'(alu_src), 64'd0);
        chk("sel_oor.const_vld", 64'(out_valid), 64'd1);

        // ---------------- Async reset during stall+kill ----------------
        set_fwd_case(5'd9);
        step("pre_rst");
        @(negedge clk);
        stall = 1'b1;
        kill  = 1'b1;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("rst_mid");
        @(negedge clk);
        reset = 1'b1;

        // ---------------- Randomized traffic ----------------
        for (int i = 0; i < 2000; i++) begin
            rand_inputs(1'b1);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
